// File: rtl/pc_sequencer_pkg.sv
// ============================================================================
// Module      : pc_sequencer_pkg
// Description : Shared encodings for the program-counter sequencer: PC-source
//               codes from the next-PC logic, FSM state codes and default
//               reset and exception vectors.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pc_sequencer_pkg;

    // PC-source codes driven by the next-PC datapath
    localparam logic [1:0] PCSRC_SEQ  = 2'b00;
    localparam logic [1:0] PCSRC_JMP  = 2'b01;
    localparam logic [1:0] PCSRC_ERET = 2'b10;
    localparam logic [1:0] PCSRC_EXC  = 2'b11;

    // Sequencer FSM states
    localparam logic [0:0] ST_FETCH = 1'b0;
    localparam logic [0:0] ST_EXEC  = 1'b1;

    // Default vectors
    localparam logic [31:0] RESET_VEC_DEFAULT = 32'hBFC0_0000;
    localparam logic [31:0] EXC_VEC_DEFAULT   = 32'h8000_0180;

endpackage

`default_nettype wire

// File: rtl/pc_target_sel.sv
// ============================================================================
// Module      : pc_target_sel
// Description : Combinational next-PC target select with alignment check.
//               A misaligned sequential/jump/ERET target is redirected to the
//               exception vector instead.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_target_sel
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] EXC_VEC = EXC_VEC_DEFAULT
) (
    input  logic [1:0]  i_pcsrc,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_nextpc,
    input  logic [31:0] i_epc,
    output logic [31:0] o_target,
    output logic        o_misaligned,
    output logic        o_enter_exc,
    output logic        o_leave_exl
);

    logic [31:0] w_raw_target;

    // Pick the raw target, then redirect to the exception vector on a trap
    always_comb begin
        w_raw_target = i_pc + 32'd4;
        case (i_pcsrc)
            PCSRC_SEQ:  w_raw_target = i_pc + 32'd4;
            PCSRC_JMP:  w_raw_target = i_nextpc;
            PCSRC_ERET: w_raw_target = i_epc;
            default:    w_raw_target = EXC_VEC;
        endcase

        // The exception vector itself is never subject to the alignment check
        o_misaligned = (i_pcsrc != PCSRC_EXC) && (w_raw_target[1:0] != 2'b00);
        o_enter_exc  = (i_pcsrc == PCSRC_EXC) || o_misaligned;
        o_leave_exl  = (i_pcsrc == PCSRC_ERET) && !o_misaligned;
        o_target     = o_enter_exc ? EXC_VEC : w_raw_target;
    end

endmodule

`default_nettype wire

// File: rtl/pc_sequencer.sv
// ============================================================================
// Module      : pc_sequencer
// Description : Architectural PC owner for the unpipelined core. Sequences
//               each instruction through FETCH/EXEC, commits the next PC,
//               maintains EPC/EXL and counts retired instructions.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_VEC = RESET_VEC_DEFAULT,
    parameter logic [31:0] EXC_VEC   = EXC_VEC_DEFAULT
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [1:0]  i_pcsrc,
    input  logic [31:0] i_nextpc,
    input  logic        i_exec_done,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_rdata,
    output logic [31:0] o_pc,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    output logic [31:0] o_instr,
    output logic        o_instr_valid,
    output logic [31:0] o_epc,
    output logic        o_exl,
    output logic        o_addr_err,
    output logic [31:0] o_instret
);

    logic [0:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_epc;
    logic        r_exl;
    logic [31:0] r_instr;
    logic        r_addr_err;
    logic [31:0] r_instret;

    logic [31:0] w_target;
    logic        w_misaligned;
    logic        w_enter_exc;
    logic        w_leave_exl;
    logic        w_commit;

    pc_target_sel #(
        .EXC_VEC (EXC_VEC)
    ) u_target_sel (
        .i_pcsrc      (i_pcsrc),
        .i_pc         (r_pc),
        .i_nextpc     (i_nextpc),
        .i_epc        (r_epc),
        .o_target     (w_target),
        .o_misaligned (w_misaligned),
        .o_enter_exc  (w_enter_exc),
        .o_leave_exl  (w_leave_exl)
    );

    assign w_commit = (r_state == ST_EXEC) && i_exec_done;

    // FSM, PC/EPC/EXL commit, instruction latch and retire counter
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= ST_FETCH;
            r_pc       <= RESET_VEC;
            r_epc      <= 32'd0;
            r_exl      <= 1'b0;
            r_instr    <= 32'd0;
            r_addr_err <= 1'b0;
            r_instret  <= 32'd0;
        end else begin
            r_addr_err <= 1'b0;
            case (r_state)
                ST_FETCH: begin
                    if (i_imem_ack) begin
                        r_instr <= i_imem_rdata;
                        r_state <= ST_EXEC;
                    end
                end
                default: begin
                    if (w_commit) begin
                        r_pc       <= w_target;
                        r_instret  <= r_instret + 32'd1;
                        r_addr_err <= w_misaligned;
                        r_state    <= ST_FETCH;
                        if (w_enter_exc) begin
                            r_exl <= 1'b1;
                            // A nested exception keeps the original return point
                            if (!r_exl) begin
                                r_epc <= r_pc;
                            end
                        end else if (w_leave_exl) begin
                            r_exl <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

    assign o_pc          = r_pc;
    assign o_imem_req    = (r_state == ST_FETCH);
    assign o_imem_addr   = r_pc;
    assign o_instr       = r_instr;
    assign o_instr_valid = (r_state == ST_EXEC);
    assign o_epc         = r_epc;
    assign o_exl         = r_exl;
    assign o_addr_err    = r_addr_err;
    assign o_instret     = r_instret;

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// ============================================================================
// Module      : tb_pc_sequencer
// Description : Self-checking bench for pc_sequencer: a table of per-
//               instruction vectors plus hand-written corner sequences.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_sequencer;

    logic        clk;
    logic        rst;
    logic [1:0]  pcsrc;
    logic [31:0] nextpc;
    logic        exec_done;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] epc;
    logic        exl;
    logic        addr_err;
    logic [31:0] instret;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_cur_pc;

    typedef struct {
        int          ack_delay;
        logic [31:0] rdata;
        logic [1:0]  src;
        logic [31:0] tgt;
        logic [31:0] exp_pc;
        logic [31:0] exp_epc;
        logic        exp_exl;
        logic        exp_aerr;
        logic [31:0] exp_instret;
    } vec_t;

    vec_t vecs[14];

    pc_sequencer dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_pcsrc       (pcsrc),
        .i_nextpc      (nextpc),
        .i_exec_done   (exec_done),
        .i_imem_ack    (imem_ack),
        .i_imem_rdata  (imem_rdata),
        .o_pc          (pc),
        .o_imem_req    (imem_req),
        .o_imem_addr   (imem_addr),
        .o_instr       (instr),
        .o_instr_valid (instr_valid),
        .o_epc         (epc),
        .o_exl         (exl),
        .o_addr_err    (addr_err),
        .o_instret     (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Fetch (with ack_delay wait cycles), execute, commit; all at negedges
    task automatic do_instr(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("v%0d", idx);
        for (int k = 0; k < v.ack_delay; k++) begin
            check({tag, ".wait_req"}, {31'd0, imem_req}, 32'd1);
            check({tag, ".wait_addr"}, imem_addr, exp_cur_pc);
            @(negedge clk);
        end
        check({tag, ".req"}, {31'd0, imem_req}, 32'd1);
        check({tag, ".addr"}, imem_addr, exp_cur_pc);
        imem_ack   = 1'b1;
        imem_rdata = v.rdata;
        @(negedge clk);
        imem_ack   = 1'b0;
        check({tag, ".instr"}, instr, v.rdata);
        check({tag, ".valid"}, {31'd0, instr_valid}, 32'd1);
        check({tag, ".exec_req"}, {31'd0, imem_req}, 32'd0);
        exec_done = 1'b1;
        pcsrc     = v.src;
        nextpc    = v.tgt;
        @(negedge clk);
        exec_done = 1'b0;
        check({tag, ".pc"}, pc, v.exp_pc);
        check({tag, ".epc"}, epc, v.exp_epc);
        check({tag, ".exl"}, {31'd0, exl}, {31'd0, v.exp_exl});
        check({tag, ".aerr"}, {31'd0, addr_err}, {31'd0, v.exp_aerr});
        check({tag, ".instret"}, instret, v.exp_instret);
        check({tag, ".back_fetch"}, {31'd0, instr_valid}, 32'd0);
        @(negedge clk);
        check({tag, ".aerr_clr"}, {31'd0, addr_err}, 32'd0);
        exp_cur_pc = v.exp_pc;
    endtask

    initial begin
        //            delay rdata          src    target         pc             epc            exl   aerr  instret
        vecs[0]  = '{3, 32'h2408_0001, 2'b00, 32'h0,         32'hBFC0_0004, 32'h0,         1'b0, 1'b0, 32'd1};
        vecs[1]  = '{0, 32'h0000_0011, 2'b01, 32'hBFC0_0100, 32'hBFC0_0100, 32'h0,         1'b0, 1'b0, 32'd2};
        vecs[2]  = '{1, 32'h0000_0012, 2'b11, 32'h0,         32'h8000_0180, 32'hBFC0_0100, 1'b1, 1'b0, 32'd3};
        vecs[3]  = '{0, 32'h0000_0013, 2'b11, 32'h0,         32'h8000_0180, 32'hBFC0_0100, 1'b1, 1'b0, 32'd4};
        vecs[4]  = '{2, 32'h0000_0014, 2'b10, 32'h0,         32'hBFC0_0100, 32'hBFC0_0100, 1'b0, 1'b0, 32'd5};
        vecs[5]  = '{0, 32'h0000_0015, 2'b00, 32'h0,         32'hBFC0_0104, 32'hBFC0_0100, 1'b0, 1'b0, 32'd6};
        vecs[6]  = '{0, 32'h0000_0016, 2'b01, 32'hBFC0_0102, 32'h8000_0180, 32'hBFC0_0104, 1'b1, 1'b1, 32'd7};
        vecs[7]  = '{0, 32'h0000_0017, 2'b10, 32'h0,         32'hBFC0_0104, 32'hBFC0_0104, 1'b0, 1'b0, 32'd8};
        vecs[8]  = '{1, 32'h0000_0018, 2'b10, 32'h0,         32'hBFC0_0104, 32'hBFC0_0104, 1'b0, 1'b0, 32'd9};
        vecs[9]  = '{0, 32'h0000_0019, 2'b01, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'hBFC0_0104, 1'b0, 1'b0, 32'd10};
        vecs[10] = '{0, 32'h0000_001A, 2'b00, 32'h0,         32'h0000_0000, 32'hBFC0_0104, 1'b0, 1'b0, 32'd11};
        vecs[11] = '{0, 32'h0000_001B, 2'b11, 32'h0,         32'h8000_0180, 32'h0000_0000, 1'b1, 1'b0, 32'd12};
        vecs[12] = '{0, 32'h0000_001C, 2'b01, 32'h0000_0003, 32'h8000_0180, 32'h0000_0000, 1'b1, 1'b1, 32'd13};
        vecs[13] = '{0, 32'h0000_001D, 2'b00, 32'h0,         32'hBFC0_0004, 32'h0000_0000, 1'b0, 1'b0, 32'd1};

        rst        = 1'b1;
        pcsrc      = 2'b00;
        nextpc     = 32'h0;
        exec_done  = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        @(negedge clk);
        @(negedge clk);
        check("rst.pc", pc, 32'hBFC0_0000);
        check("rst.epc", epc, 32'h0);
        check("rst.exl", {31'd0, exl}, 32'd0);
        check("rst.instr", instr, 32'h0);
        check("rst.instret", instret, 32'h0);
        check("rst.aerr", {31'd0, addr_err}, 32'd0);
        check("rst.req", {31'd0, imem_req}, 32'd1);
        rst = 1'b0;
        exp_cur_pc = 32'hBFC0_0000;

        for (int i = 0; i < 13; i++) begin
            do_instr(vecs[i], i);
        end

        // exec_done during FETCH must be ignored
        exec_done = 1'b1;
        pcsrc     = 2'b01;
        nextpc    = 32'hBFC0_0200;
        @(negedge clk);
        exec_done = 1'b0;
        check("fetch_ignore.pc", pc, 32'h8000_0180);
        check("fetch_ignore.req", {31'd0, imem_req}, 32'd1);
        check("fetch_ignore.instret", instret, 32'd13);

        // ack during EXEC must not reload the instruction
        imem_ack   = 1'b1;
        imem_rdata = 32'hAAAA_5555;
        @(negedge clk);
        imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        imem_ack = 1'b0;
        check("exec_ignore.instr", instr, 32'hAAAA_5555);
        check("exec_ignore.valid", {31'd0, instr_valid}, 32'd1);

        // Commit sequential, then reset asynchronously with a fetch pending
        exec_done = 1'b1;
        pcsrc     = 2'b00;
        @(negedge clk);
        exec_done = 1'b0;
        check("pre_rst.pc", pc, 32'h8000_0184);
        check("pre_rst.req", {31'd0, imem_req}, 32'd1);
        #3;
        rst = 1'b1;
        #1;
        check("async_rst.pc", pc, 32'hBFC0_0000);
        check("async_rst.exl", {31'd0, exl}, 32'd0);
        check("async_rst.instret", instret, 32'h0);
        check("async_rst.epc", epc, 32'h0);
        check("async_rst.instr", instr, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        exp_cur_pc = 32'hBFC0_0000;
        do_instr(vecs[13], 13);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog so the bench always ends
    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
